// File: rtl/grf_pkg.sv
// +------------------------------------------------------------------+
// | grf_pkg: shared constants and packed-port slice helper for GRF   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

// Selects element k of width w from a packed multi-port vector.
`define GRF_SLICE(vec, k, w) vec[(k)*(w) +: (w)]

package grf_pkg;
  localparam int REG_ZERO   = 0;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
endpackage

`default_nettype wire

// File: rtl/grf_wr_arbiter.sv
// +------------------------------------------------------------------+
// | grf_wr_arbiter: picks the highest-index enabled write to target  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module grf_wr_arbiter
  import grf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_WR = 2
) (
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0]        target,
  output logic                     hit,
  output logic [DATA_W-1:0]        data
);

  // Ascending scan: a later match overwrites earlier ones, so the highest index wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j] && (`GRF_SLICE(wr_addr, j, ADDR_W) == target)) begin
        hit  = 1'b1;
        data = `GRF_SLICE(wr_data, j, DATA_W);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/grf_multiport.sv
// +------------------------------------------------------------------+
// | grf_multiport: multi-port register file with pending scoreboard  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module grf_multiport
  import grf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter int BYPASS = 1,
  parameter int TRACE  = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pend,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_WR*32-1:0]     wr_pc,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pend;

  // Register 0 has no commit path, so the commit vectors start at 1.
  logic [DEPTH-1:1]  commit_hit;
  logic [DATA_W-1:0] commit_data [1:DEPTH-1];

  for (genvar i = 1; i < DEPTH; i++) begin : g_commit
    grf_wr_arbiter #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NUM_WR (NUM_WR)
    ) u_commit_arb (
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .target  (ADDR_W'(i)),
      .hit     (commit_hit[i]),
      .data    (commit_data[i])
    );
  end

  // Issue is applied after writeback so a same-edge set beats the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      pend <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (commit_hit[i]) begin
          regs[i] <= commit_data[i];
          pend[i] <= 1'b0;
        end
        if (iss_en && (iss_addr == ADDR_W'(i))) begin
          pend[i] <= 1'b1;
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              byp_hit;
    logic [DATA_W-1:0] byp_data;

    assign addr = `GRF_SLICE(rd_addr, k, ADDR_W);

    if (BYPASS != 0) begin : g_byp
      grf_wr_arbiter #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NUM_WR (NUM_WR)
      ) u_byp_arb (
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .target  (addr),
        .hit     (byp_hit),
        .data    (byp_data)
      );
    end else begin : g_nobyp
      assign byp_hit  = 1'b0;
      assign byp_data = '0;
    end

    always_comb begin
      `GRF_SLICE(rd_data, k, DATA_W) = regs[addr];
      rd_pend[k]                     = pend[addr];
      if (addr == ZERO_ADDR) begin
        `GRF_SLICE(rd_data, k, DATA_W) = '0;
        rd_pend[k]                     = 1'b0;
      end else if (byp_hit) begin
        `GRF_SLICE(rd_data, k, DATA_W) = byp_data;
        rd_pend[k]                     = 1'b0;
      end
    end
  end

  if (TRACE != 0) begin : g_trace
`ifndef SYNTHESIS
    logic [NUM_WR-1:0] trace_win;

    // A port is traced only if no higher-index enabled port hits the same address.
    always_comb begin
      trace_win = '0;
      for (int j = 0; j < NUM_WR; j++) begin
        trace_win[j] = wr_en[j] && (`GRF_SLICE(wr_addr, j, ADDR_W) != ZERO_ADDR);
        for (int m = j + 1; m < NUM_WR; m++) begin
          if (wr_en[m] && (`GRF_SLICE(wr_addr, m, ADDR_W) == `GRF_SLICE(wr_addr, j, ADDR_W))) begin
            trace_win[j] = 1'b0;
          end
        end
      end
    end

    always @(posedge clk) begin
      if (!reset) begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (trace_win[j]) begin
            $display("@%h: $%d <= %h", `GRF_SLICE(wr_pc, j, 32),
                     `GRF_SLICE(wr_addr, j, ADDR_W), `GRF_SLICE(wr_data, j, DATA_W));
          end
        end
      end
    end
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_grf_multiport.sv
// +------------------------------------------------------------------+
// | tb_grf_multiport: scoreboard bench, bypass and non-bypass DUTs   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_grf_multiport;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [NR*AW-1:0] rd_addr;
  logic [NW-1:0]    wr_en;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic [NW*32-1:0] wr_pc;
  logic             iss_en;
  logic [AW-1:0]    iss_addr;

  logic [NR*DW-1:0] rd_data_b, rd_data_n;
  logic [NR-1:0]    rd_pend_b, rd_pend_n;

  always #5 clk = ~clk;

  grf_multiport #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(1), .TRACE(1)) dut_byp (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_pend(rd_pend_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_pc(wr_pc),
    .iss_en(iss_en), .iss_addr(iss_addr));

  grf_multiport #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(0), .TRACE(1)) dut_nobyp (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_pend(rd_pend_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_pc(wr_pc),
    .iss_en(iss_en), .iss_addr(iss_addr));

  typedef struct {
    string       tag;
    int          dut;
    int          port;
    bit          is_pend;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t   sb[$];
  logic [31:0] m_regs [32];
  bit          m_pend [32];
  bit          model_valid = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input int byp, input logic [4:0] a);
    logic [31:0] v;
    if (a == 5'd0) return 32'h0;
    v = m_regs[a];
    if (byp != 0) begin
      for (int j = 0; j < NW; j++)
        if (wr_en[j] && wr_addr[j*AW +: AW] == a) v = wr_data[j*DW +: DW];
    end
    return v;
  endfunction

  function automatic logic [31:0] exp_pend(input int byp, input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (byp != 0) begin
      for (int j = 0; j < NW; j++)
        if (wr_en[j] && wr_addr[j*AW +: AW] == a) return 32'h0;
    end
    return {31'h0, m_pend[a]};
  endfunction

  function automatic logic [31:0] actual(input sb_entry_t e);
    if (e.dut == 0)
      return e.is_pend ? {31'h0, rd_pend_b[e.port]} : rd_data_b[e.port*DW +: DW];
    return e.is_pend ? {31'h0, rd_pend_n[e.port]} : rd_data_n[e.port*DW +: DW];
  endfunction

  task automatic step(input bit rst, input logic [1:0] we,
                      input logic [4:0] wa0, input logic [31:0] wd0,
                      input logic [4:0] wa1, input logic [31:0] wd1,
                      input bit ie, input logic [4:0] ia,
                      input logic [4:0] ra0, input logic [4:0] ra1);
    sb_entry_t e;
    reset    = rst;
    wr_en    = we;
    wr_addr  = {wa1, wa0};
    wr_data  = {wd1, wd0};
    wr_pc    = {32'h1000 + 32'(cyc) * 8 + 32'd4, 32'h1000 + 32'(cyc) * 8};
    iss_en   = ie;
    iss_addr = ia;
    rd_addr  = {ra1, ra0};
    #1;
    if (model_valid) begin
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < NR; k++) begin
          e.dut = d; e.port = k;
          e.is_pend = 1'b0;
          e.exp = exp_data(d == 0 ? 1 : 0, rd_addr[k*AW +: AW]);
          e.tag = $sformatf("c%0d_%s_rd%0d_data", cyc, d == 0 ? "byp" : "nobyp", k);
          sb.push_back(e);
          e.is_pend = 1'b1;
          e.exp = exp_pend(d == 0 ? 1 : 0, rd_addr[k*AW +: AW]);
          e.tag = $sformatf("c%0d_%s_rd%0d_pend", cyc, d == 0 ? "byp" : "nobyp", k);
          sb.push_back(e);
        end
      end
    end
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, actual(e), e.exp);
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = 32'h0;
        m_pend[i] = 1'b0;
      end
      model_valid = 1'b1;
    end else begin
      for (int j = 0; j < NW; j++) begin
        if (we[j] && wr_addr[j*AW +: AW] != 5'd0) begin
          m_regs[wr_addr[j*AW +: AW]] = wr_data[j*DW +: DW];
          m_pend[wr_addr[j*AW +: AW]] = 1'b0;
        end
      end
      if (ie && ia != 5'd0) m_pend[ia] = 1'b1;
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0; wr_pc = '0;
    iss_en = 1'b0; iss_addr = '0; rd_addr = '0;
    @(negedge clk);
    // T1 reset, including reset overriding a same-cycle write
    step(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 2'b00, 0, 0, 0, 0, 0, 0, 5, 0);
    step(0, 2'b01, 5, 32'hDEADBEEF, 0, 0, 0, 0, 5, 1);
    step(0, 2'b00, 0, 0, 0, 0, 1, 5, 5, 0);
    step(1, 2'b01, 5, 32'hDEADBEEF, 0, 0, 1, 5, 5, 0);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 5, 5);
    // T2 bypass versus stored value
    step(0, 2'b01, 7, 32'h12345678, 0, 0, 0, 0, 7, 6);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 7, 7);
    // T3 write conflict, highest port wins (also visible through bypass)
    step(0, 2'b11, 9, 32'h1, 9, 32'h2, 0, 0, 9, 7);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 9, 9);
    // T4 register 0 ignores writes and issue
    step(0, 2'b11, 0, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 0, 0, 0, 0);
    step(0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    // T5 scoreboard set then clear by writeback
    step(0, 2'b00, 0, 0, 0, 0, 1, 3, 3, 0);
    step(0, 2'b10, 0, 0, 3, 32'hCAFE0003, 0, 0, 3, 0);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 3, 3);
    // T6 same-edge issue and writeback: set wins
    step(0, 2'b01, 4, 32'hABCD0004, 0, 0, 1, 4, 4, 0);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 4, 4);
    step(0, 2'b00, 0, 0, 0, 0, 1, 4, 4, 0);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 4, 0);
    // Random traffic over a narrow address range to provoke conflicts and races
    for (int n = 0; n < 200; n++) begin
      step(($urandom_range(0, 49) == 0),
           2'($urandom_range(0, 3)),
           5'($urandom_range(0, 7)), $urandom(),
           5'($urandom_range(0, 7)), $urandom(),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
